// File: rtl/ysyx_25010008_axi_sram_slave.sv
// ----------------------------------------------------------------------------
// ysyx_25010008_axi_sram_slave
//   AXI4 responder backed by an on-chip word SRAM. It answers the NPC master
//   port in sim/FPGA builds. Only one transaction is in flight at a time.
//   Bursts are always INCR, up to 256 beats, with beat sizes of 1, 2 or 4 bytes.
//
// Parameters
//   DEPTH_WORDS : SRAM depth in 32-bit words
//   BASE_ADDR   : first mapped byte address
//   RD_LATENCY  : cycles from AR accept (or the previous R handshake) to rvalid (>=1)
//
// Ports
//   clock, reset           : rising-edge clock; asynchronous active-low reset
//   aw* / w* / b*          : write address, write data and write response channels
//   ar* / r*               : read address and read data channels
//
// Configuration macro
//   AXI_SLV_STALL_EN : when defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed A5)
//                      inserts random stalls. Whenever bit0 is 1, the ready
//                      outputs are held low and rvalid/bvalid are delayed.
// ----------------------------------------------------------------------------
module ysyx_25010008_axi_sram_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready,
  input  logic        awvalid,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        arready,
  input  logic        arvalid,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        rready,
  output logic        rvalid,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_RWAIT = 3'd1;
  localparam logic [2:0]  S_RDATA = 3'd2;
  localparam logic [2:0]  S_WDATA = 3'd3;
  localparam logic [2:0]  S_WRESP = 3'd4;
  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);
  localparam logic [7:0]  LAT_RLD = 8'(RD_LATENCY - 1);
  localparam logic [1:0]  SLVERR  = 2'b10;

  logic stall;
`ifdef AXI_SLV_STALL_EN
  localparam bit STALL_EN = 1'b1;
  logic [7:0] lfsr_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign stall = lfsr_q[0];
`else
  localparam bit STALL_EN = 1'b0;
  assign stall = 1'b0;
`endif

  logic [31:0] mem [DEPTH_WORDS];

  logic [2:0]  state_q, state_d;
  logic        arb_pri_q, arb_pri_d;   // 0: read wins a tie, 1: write wins
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d, lat_q, lat_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  id_q, id_d;
  logic        err_q, err_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d, bvalid_q, bvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // Offset is unsigned, so addresses below BASE_ADDR wrap high and fail the range check.
  logic [31:0]      off;
  logic             beat_err, beat_last, grant_rd, grant_wr, idle_ok, we;
  logic [IDX_W-1:0] idx;
  logic [31:0]      step;

  assign off       = addr_q - BASE_ADDR;
  assign beat_err  = (size_q > 3'd2) || (off >= SPAN);
  assign idx       = off[IDX_W+1:2];
  assign beat_last = (cnt_q == len_q);
  assign step      = 32'd1 << size_q;

  assign grant_rd = arvalid && (!awvalid || !arb_pri_q);
  assign grant_wr = awvalid && (!arvalid ||  arb_pri_q);
  // The reset term keeps both ready outputs at 0 while reset is asserted.
  assign idle_ok  = (state_q == S_IDLE) && reset && !stall;
  assign arready  = idle_ok && !grant_wr;
  assign awready  = idle_ok && !grant_rd;
  assign wready   = (state_q == S_WDATA) && !stall;
  assign we       = wvalid && wready && !beat_err;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;
  assign rid    = id_q;
  assign bvalid = bvalid_q;
  assign bid    = id_q;
  assign bresp  = err_q ? SLVERR : 2'b00;

  always_comb begin
    state_d   = state_q;
    arb_pri_d = arb_pri_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    err_d     = err_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    bvalid_d  = bvalid_q;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready) begin
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          id_d    = arid;
          cnt_d   = 8'd0;
          lat_d   = LAT_RLD;
          state_d = S_RWAIT;
          if (awvalid) arb_pri_d = 1'b1;
        end else if (awvalid && awready) begin
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          id_d    = awid;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_WDATA;
          if (arvalid) arb_pri_d = 1'b0;
        end
      end
      S_RWAIT: begin
        if (lat_q != 8'd0) begin
          lat_d = lat_q - 8'd1;
        end else if (!stall) begin
          rvalid_d = 1'b1;
          rdata_d  = beat_err ? 32'd0 : mem[idx];
          rresp_d  = beat_err ? SLVERR : 2'b00;
          rlast_d  = beat_last;
          state_d  = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + step;
            cnt_d   = cnt_q + 8'd1;
            lat_d   = LAT_RLD;
            state_d = S_RWAIT;
          end
        end
      end
      S_WDATA: begin
        if (wvalid && wready) begin
          // The beat count ends the burst; a wlast that disagrees only flags an error.
          if (beat_err || (wlast != beat_last)) err_d = 1'b1;
          addr_d = addr_q + step;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) begin
            state_d  = S_WRESP;
            bvalid_d = !STALL_EN;
          end
        end
      end
      S_WRESP: begin
        if (bvalid_q && bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end else if (!bvalid_q && !stall) begin
          bvalid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      arb_pri_q <= 1'b0;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      id_q      <= 4'd0;
      cnt_q     <= 8'd0;
      lat_q     <= 8'd0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_pri_q <= arb_pri_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // SRAM contents are not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
